vga_plot_scheduler: RTL and testbench

//  Shares the single VGA adapter pixel-write port (VGA_X/VGA_Y/VGA_COLOR/plot) between N_REQ drawing

---
 rtl/vga_pkg.sv | 14 +
 rtl/vga_plot_scheduler_if.sv | 30 +++
 rtl/vga_plot_scheduler_rr_arbiter.sv | 53 +++++
 rtl/vga_plot_scheduler.sv | 137 +++++++++++++
 tb/tb_vga_plot_scheduler.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared widths, default screen geometry and FSM state encoding for the
// VGA plot scheduler slice.
package vga_pkg;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int C_W      = 3;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_ARB   = 1'b1;

endpackage

// File: rtl/vga_plot_scheduler_if.sv
// Pixel requester bus: N_REQ packed pixel sources with a one-hot ready.
// master = drawing requesters, slave = vga_plot_scheduler.
interface vga_plot_scheduler_if #(
    parameter int N_REQ = 2
);
    import vga_pkg::*;

    logic [N_REQ-1:0]     req_valid;
    logic [X_W*N_REQ-1:0] req_x;
    logic [Y_W*N_REQ-1:0] req_y;
    logic [C_W*N_REQ-1:0] req_color;
    logic [N_REQ-1:0]     req_ready;

    modport master (
        output req_valid,
        output req_x,
        output req_y,
        output req_color,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_x,
        input  req_y,
        input  req_color,
        output req_ready
    );

endinterface

// File: rtl/vga_plot_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or above the
// pointer (wrapping), pointer moves just past the winner after each grant.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic [PW-1:0] cand;
    logic          found;
    int unsigned   idx;

    // Search from the pointer upward with wrap; first valid requester wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        win   = '0;
        cand  = '0;
        idx   = 0;
        if (enable) begin
            for (int unsigned off = 0; off < N; off++) begin
                idx = 32'(ptr) + off;
                if (idx >= N) begin
                    idx = idx - N;
                end
                cand = PW'(idx);
                if (!found && req[cand]) begin
                    grant[cand] = 1'b1;
                    found       = 1'b1;
                    win         = cand;
                end
            end
        end
    end

    // Advance the pointer past the requester that was just granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (win == PW'(N - 1)) ? '0 : win + 1'b1;
        end
    end

endmodule

// File: rtl/vga_plot_scheduler.sv
// Shares the VGA adapter pixel-write port between N_REQ requesters with
// round-robin arbitration, and paints the whole screen with BG_COLOR after
// reset and on clear_req. Optional macro PLOT_CLIP_EN: drop (and count)
// accepted pixels that fall outside the screen.
module vga_plot_scheduler
    import vga_pkg::*;
#(
    parameter int             N_REQ    = 2,
    parameter int             X_MAX    = SCREEN_W,
    parameter int             Y_MAX    = SCREEN_H,
    parameter logic [C_W-1:0] BG_COLOR = 3'b000
) (
    input  logic                  CLOCK_50,
    input  logic                  Resetn,
    input  logic                  clear_req,
    vga_plot_scheduler_if.slave   req_bus,
    output logic                  busy,
    output logic                  clear_done,
    output logic [15:0]           drop_cnt,
    output logic [X_W-1:0]        VGA_X,
    output logic [Y_W-1:0]        VGA_Y,
    output logic [C_W-1:0]        VGA_COLOR,
    output logic                  plot
);

    localparam logic [X_W-1:0] X_LAST = X_W'(X_MAX - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_MAX - 1);

    logic [0:0]       state;
    logic [X_W-1:0]   cx;
    logic [Y_W-1:0]   cy;
    logic             arb_en;
    logic [N_REQ-1:0] grant;
    logic             accept;
    logic             clip;
    logic [X_W-1:0]   sel_x;
    logic [Y_W-1:0]   sel_y;
    logic [C_W-1:0]   sel_c;

    // A clear request in ARB pre-empts any simultaneous pixel request.
    assign arb_en = (state == ST_ARB) && !clear_req;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk    (CLOCK_50),
        .rst_n  (Resetn),
        .enable (arb_en),
        .req    (req_bus.req_valid),
        .grant  (grant)
    );

    assign req_bus.req_ready = grant;
    assign accept            = |grant;
    assign busy              = (state == ST_CLEAR);

    // Route the granted requester's pixel fields (grant is one-hot).
    always_comb begin
        sel_x = '0;
        sel_y = '0;
        sel_c = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_x = sel_x | req_bus.req_x[X_W*i +: X_W];
                sel_y = sel_y | req_bus.req_y[Y_W*i +: Y_W];
                sel_c = sel_c | req_bus.req_color[C_W*i +: C_W];
            end
        end
    end

`ifdef PLOT_CLIP_EN
    localparam logic [X_W:0] X_LIM = (X_W + 1)'(X_MAX);
    localparam logic [Y_W:0] Y_LIM = (Y_W + 1)'(Y_MAX);

    assign clip = accept && (({1'b0, sel_x} >= X_LIM) || ({1'b0, sel_y} >= Y_LIM));

    // Count clipped pixels, saturating at all-ones.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            drop_cnt <= '0;
        end else if (clip && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
`else
    assign clip     = 1'b0;
    assign drop_cnt = '0;
`endif

    // CLEAR sweeps the screen one pixel per cycle; ARB forwards granted pixels.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state      <= ST_CLEAR;
            cx         <= '0;
            cy         <= '0;
            VGA_X      <= '0;
            VGA_Y      <= '0;
            VGA_COLOR  <= '0;
            plot       <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    VGA_X     <= cx;
                    VGA_Y     <= cy;
                    VGA_COLOR <= BG_COLOR;
                    plot      <= 1'b1;
                    if (cx == X_LAST) begin
                        cx <= '0;
                        if (cy == Y_LAST) begin
                            cy         <= '0;
                            state      <= ST_ARB;
                            clear_done <= 1'b1;
                        end else begin
                            cy <= cy + 1'b1;
                        end
                    end else begin
                        cx <= cx + 1'b1;
                    end
                end
                default: begin
                    if (clear_req) begin
                        state <= ST_CLEAR;
                        plot  <= 1'b0;
                    end else if (accept && !clip) begin
                        VGA_X     <= sel_x;
                        VGA_Y     <= sel_y;
                        VGA_COLOR <= sel_c;
                        plot      <= 1'b1;
                    end else begin
                        plot <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_plot_scheduler.sv
// Self-checking bench for vga_plot_scheduler: random requester traffic and
// directed scenarios compared against a screen-level reference model.
module tb_vga_plot_scheduler;
    import vga_pkg::*;

    localparam int N  = 2;
    localparam int W  = 160;
    localparam int H  = 120;
    localparam int BG = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear_req = 1'b0;
    logic        busy;
    logic        clear_done;
    logic [15:0] drop_cnt;
    logic [7:0]  vx;
    logic [6:0]  vy;
    logic [2:0]  vc;
    logic        plot;

    vga_plot_scheduler_if #(.N_REQ(N)) bus ();

    vga_plot_scheduler #(
        .N_REQ    (N),
        .X_MAX    (W),
        .Y_MAX    (H),
        .BG_COLOR (3'b000)
    ) dut (
        .CLOCK_50   (clk),
        .Resetn     (rst_n),
        .clear_req  (clear_req),
        .req_bus    (bus),
        .busy       (busy),
        .clear_done (clear_done),
        .drop_cnt   (drop_cnt),
        .VGA_X      (vx),
        .VGA_Y      (vy),
        .VGA_COLOR  (vc),
        .plot       (plot)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Requester sources
    bit pv[N];
    int px[N];
    int py[N];
    int pc[N];

    // Reference model: screen-level view of the scheduler
    bit m_clear;
    int m_idx;
    int m_ptr;
    int m_x, m_y, m_c;
    bit m_plot;
    bit m_done;
    int m_drop;

    task automatic model_reset();
        m_clear = 1'b1;
        m_idx   = 0;
        m_ptr   = 0;
        m_x     = 0;
        m_y     = 0;
        m_c     = 0;
        m_plot  = 1'b0;
        m_done  = 1'b0;
        m_drop  = 0;
    endtask

    function automatic int model_pick();
        if (m_clear || clear_req) return -1;
        for (int k = 0; k < N; k++) begin
            if (pv[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic drive_bus();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]           = pv[i];
            bus.req_x[8*i +: 8]        = 8'(px[i]);
            bus.req_y[7*i +: 7]        = 7'(py[i]);
            bus.req_color[3*i +: 3]    = 3'(pc[i]);
        end
    endtask

    task automatic new_pixel(input int i, input bit allow_oob);
        pv[i] = 1'b1;
        px[i] = $urandom_range(0, W - 1);
        py[i] = $urandom_range(0, H - 1);
        pc[i] = $urandom_range(0, 7);
        if (allow_oob && ($urandom_range(0, 7) == 0)) px[i] = $urandom_range(W, 255);
        if (allow_oob && ($urandom_range(0, 7) == 0)) py[i] = $urandom_range(H, 127);
    endtask

    // One clock cycle: inputs are applied just after a falling edge.
    task automatic run_cycle();
        int pick;
        bit clipped;
        logic [N-1:0] exp_rdy;
        drive_bus();
        #1;
        pick    = model_pick();
        exp_rdy = '0;
        if (pick >= 0) exp_rdy[pick] = 1'b1;
        check_val("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        check_val("busy", 32'(busy), 32'(m_clear));
        m_done = 1'b0;
        if (m_clear) begin
            m_x    = m_idx % W;
            m_y    = m_idx / W;
            m_c    = BG;
            m_plot = 1'b1;
            if (m_idx == W * H - 1) begin
                m_clear = 1'b0;
                m_done  = 1'b1;
            end else begin
                m_idx++;
            end
        end else if (clear_req) begin
            m_clear = 1'b1;
            m_idx   = 0;
            m_plot  = 1'b0;
        end else if (pick >= 0) begin
            m_ptr   = (pick + 1) % N;
            clipped = 1'b0;
`ifdef PLOT_CLIP_EN
            clipped = (px[pick] >= W) || (py[pick] >= H);
`endif
            if (clipped) begin
                m_plot = 1'b0;
                if (m_drop < 65535) m_drop++;
            end else begin
                m_x    = px[pick];
                m_y    = py[pick];
                m_c    = pc[pick];
                m_plot = 1'b1;
            end
        end else begin
            m_plot = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        check_val("plot", 32'(plot), 32'(m_plot));
        check_val("vga_x", 32'(vx), 32'(m_x));
        check_val("vga_y", 32'(vy), 32'(m_y));
        check_val("vga_color", 32'(vc), 32'(m_c));
        check_val("clear_done", 32'(clear_done), 32'(m_done));
        check_val("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        if (pick >= 0) pv[pick] = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_plot"}, 32'(plot), 0);
        check_val({tag, "_x"}, 32'(vx), 0);
        check_val({tag, "_y"}, 32'(vy), 0);
        check_val({tag, "_color"}, 32'(vc), 0);
        check_val({tag, "_done"}, 32'(clear_done), 0);
        check_val({tag, "_drop"}, 32'(drop_cnt), 0);
        check_val({tag, "_ready"}, 32'(bus.req_ready), 0);
        check_val({tag, "_busy"}, 32'(busy), 1);
    endtask

    initial begin
        int plots;
        int dones;

        model_reset();
        for (int i = 0; i < N; i++) begin
            pv[i] = 1'b0; px[i] = 0; py[i] = 0; pc[i] = 0;
        end
        pv[0] = 1'b1;
        drive_bus();
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        pv[0] = 1'b0;
        rst_n = 1'b1;

        // Power-up sweep
        plots = 0;
        dones = 0;
        while (m_clear) begin
            run_cycle();
            if (plot === 1'b1) plots++;
            if (clear_done === 1'b1) dones++;
        end
        check_val("sweep_plots", 32'(plots), W * H);
        check_val("sweep_done_pulses", 32'(dones), 1);
        check_val("sweep_last_x", 32'(vx), W - 1);
        check_val("sweep_last_y", 32'(vy), H - 1);

        // Single pixel from requester 0
        pv[0] = 1'b1; px[0] = 10; py[0] = 20; pc[0] = 4;
        run_cycle();
        check_val("single_plot", 32'(plot), 1);
        check_val("single_x", 32'(vx), 10);
        check_val("single_color", 32'(vc), 4);
        run_cycle();

        // Both requesters continuously valid
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < N; i++) if (!pv[i]) new_pixel(i, 1'b0);
            run_cycle();
        end

        // Out-of-range pixel
        pv[0] = 1'b1; px[0] = 200; py[0] = 5; pc[0] = 7;
        pv[1] = 1'b0;
        run_cycle();
`ifdef PLOT_CLIP_EN
        check_val("oob_plot", 32'(plot), 0);
        check_val("oob_drop", 32'(drop_cnt), 1);
`else
        check_val("oob_plot", 32'(plot), 1);
        check_val("oob_x", 32'(vx), 200);
`endif

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pv[i] && ($urandom_range(0, 1) == 1)) new_pixel(i, 1'b1);
            end
            run_cycle();
        end

        // Clear request with requester 1 pending
        for (int i = 0; i < N; i++) pv[i] = 1'b0;
        new_pixel(1, 1'b0);
        clear_req = 1'b1;
        run_cycle();
        clear_req = 1'b0;
        while (m_clear) run_cycle();
        run_cycle();
        check_val("post_clear_plot", 32'(plot), 1);
        check_val("post_clear_x", 32'(vx), 32'(px[1]));

        // Reset in the middle of a sweep
        clear_req = 1'b1;
        run_cycle();
        clear_req = 1'b0;
        while (m_idx < 5000) run_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_cycle();
        check_val("restart_x", 32'(vx), 0);
        check_val("restart_y", 32'(vy), 0);
        while (m_clear) run_cycle();

        for (int c = 0; c < 50; c++) begin
            for (int i = 0; i < N; i++) if (!pv[i]) new_pixel(i, 1'b1);
            run_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
